// File: rtl/down_timer_ctrl.sv
// Programmable down-timer controller: loads a count, paces decrements via a
// prescaler, and pulses done at terminal count (one-shot or auto-reload).
module down_timer_ctrl #(
  parameter int N  = 4,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic [N-1:0]  load_val,
  input  logic [PW-1:0] presc,
  input  logic          mode,
  output logic [N-1:0]  q,
  output logic          busy,
  output logic          done,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e        state_q;
  logic [N-1:0]  q_q, reload_q;
  logic [PW-1:0] pcnt_q, presc_q;
  logic          mode_q, done_q;
  logic          tick_d, term_d;

  assign tick_d = (pcnt_q == presc_q);
  assign term_d = (q_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      q_q      <= '0;
      pcnt_q   <= '0;
      done_q   <= 1'b0;
      reload_q <= '0;
      presc_q  <= '0;
      mode_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state_q <= S_IDLE;
        q_q     <= '0;
        pcnt_q  <= '0;
      end else if (start) begin
        reload_q <= load_val;
        presc_q  <= presc;
        mode_q   <= mode;
        q_q      <= load_val;
        pcnt_q   <= '0;
        state_q  <= S_RUN;
      end else begin
        case (state_q)
          S_RUN, S_HOLD: begin
            if (pause) begin
              state_q <= S_HOLD;
            end else if (!tick_d) begin
              // Leaving HOLD counts this edge too, so a pause costs exactly its length.
              state_q <= S_RUN;
              pcnt_q  <= pcnt_q + 1'b1;
            end else begin
              pcnt_q <= '0;
              if (!term_d) begin
                state_q <= S_RUN;
                q_q     <= q_q - 1'b1;
              end else begin
                done_q <= 1'b1;
                if (mode_q) begin
                  state_q <= S_RUN;
                  q_q     <= reload_q;
                end else begin
                  state_q <= S_DONE;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign q     = q_q;
  assign done  = done_q;
  assign state = state_q;
  assign busy  = (state_q == S_RUN) || (state_q == S_HOLD);

endmodule
